// File: rtl/psram_xfer.sv
// psram_xfer: single-transfer PSRAM serial engine (SPI/QSPI/QPI/OPI, SCK mode 0).
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   en_i, mode_i, pscr_i       controller enable, lane mode, SCK prescaler
//   start_i, wr_i, cmd_i,      one-cycle request, direction, opcode,
//   wait_i, addr_i, wdata_i    dummy SCK cycles, byte address, write byte
//   rdata_o, busy_o, done_o    read byte, transfer active, completion pulse
//   psram_sck_o, psram_ce_o    serial clock, chip enable (active low)
//   psram_io_en_o/out_o/in_i   per-pad output enable, output data, input data
module psram_xfer #(
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [1:0]            mode_i,
  input  logic [7:0]            pscr_i,
  input  logic                  start_i,
  input  logic                  wr_i,
  input  logic [7:0]            cmd_i,
  input  logic [7:0]            wait_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  psram_sck_o,
  output logic                  psram_ce_o,
  output logic [7:0]            psram_io_en_o,
  output logic [7:0]            psram_io_out_o,
  input  logic [7:0]            psram_io_in_i
);

  localparam int unsigned SR_W = ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, STOP} state_t;

  // Lane count of a phase for the captured mode.
  function automatic logic [3:0] lanes_f(input logic [1:0] mode, input state_t ph);
    case (mode)
      2'b00:   lanes_f = 4'd1;
      2'b01:   lanes_f = (ph == CMD) ? 4'd1 : 4'd4;
      2'b10:   lanes_f = 4'd4;
      default: lanes_f = 4'd8;
    endcase
  endfunction

  // SCK cycles needed to move a phase over its lanes.
  function automatic logic [7:0] beats_f(input logic [3:0] ln, input state_t ph);
    if (ph == ADDR) begin
      case (ln)
        4'd1:    beats_f = 8'(ADDR_WIDTH);
        4'd4:    beats_f = 8'(ADDR_WIDTH / 4);
        default: beats_f = 8'(ADDR_WIDTH / 8);
      endcase
    end else begin
      case (ln)
        4'd1:    beats_f = 8'd8;
        4'd4:    beats_f = 8'd2;
        default: beats_f = 8'd1;
      endcase
    end
  endfunction

  function automatic logic [7:0] en_f(input logic [3:0] ln);
    case (ln)
      4'd1:    en_f = 8'h01;
      4'd4:    en_f = 8'h0F;
      default: en_f = 8'hFF;
    endcase
  endfunction

  // Current beat is always the MSBs of the shift register.
  function automatic logic [7:0] drive_f(input logic [3:0] ln, input logic [SR_W-1:0] sr);
    case (ln)
      4'd1:    drive_f = {7'b0, sr[SR_W-1]};
      4'd4:    drive_f = {4'b0, sr[SR_W-1 -: 4]};
      default: drive_f = sr[SR_W-1 -: 8];
    endcase
  endfunction

  function automatic logic [SR_W-1:0] shift_f(input logic [3:0] ln, input logic [SR_W-1:0] sr);
    case (ln)
      4'd1:    shift_f = {sr[SR_W-2:0], 1'b0};
      4'd4:    shift_f = {sr[SR_W-5:0], 4'b0};
      default: shift_f = {sr[SR_W-9:0], 8'b0};
    endcase
  endfunction

  // SPI reads come back on io[1]; wider modes use the low lanes.
  function automatic logic [7:0] sample_f(input logic [3:0] ln, input logic [7:0] rx,
                                          input logic [7:0] din);
    case (ln)
      4'd1:    sample_f = {rx[6:0], din[1]};
      4'd4:    sample_f = {rx[3:0], din[3:0]};
      default: sample_f = din;
    endcase
  endfunction

  state_t          state_q, state_n;
  logic [7:0]      cnt_q, cnt_n, beat_q, beat_n, rx_q, rx_n;
  logic [SR_W-1:0] sr_q, sr_n;
  logic            sck_q, sck_n, ce_q, ce_n, busy_q, busy_n, done_q, done_n;
  logic [7:0]      io_en_q, io_en_n, io_out_q, io_out_n, rdata_q, rdata_n;

  logic            wr_q;
  logic [1:0]      mode_q;
  logic [7:0]      wait_q, pscr_q, wdata_q;
  logic [SR_W-1:0] addr_q;

  logic            accept, tick, update_io, drive;
  logic [7:0]      prd, beats;
  logic [3:0]      ln, ln_n;

  assign accept = (state_q == IDLE) && start_i && en_i;
  assign prd    = (pscr_q < 8'd2) ? 8'd2 : pscr_q;
  assign tick   = (cnt_q == 8'(prd - 8'd1));

  // Request fields held for the whole transfer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q    <= 1'b0;
      mode_q  <= 2'b00;
      wait_q  <= 8'd0;
      pscr_q  <= 8'd0;
      wdata_q <= 8'd0;
      addr_q  <= '0;
    end else if (accept) begin
      wr_q    <= wr_i;
      mode_q  <= mode_i;
      wait_q  <= wait_i;
      pscr_q  <= pscr_i;
      wdata_q <= wdata_i;
      addr_q  <= addr_i;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      beat_q   <= 8'd0;
      rx_q     <= 8'd0;
      sr_q     <= '0;
      sck_q    <= 1'b0;
      ce_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      io_en_q  <= 8'h00;
      io_out_q <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      beat_q   <= beat_n;
      rx_q     <= rx_n;
      sr_q     <= sr_n;
      sck_q    <= sck_n;
      ce_q     <= ce_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      io_en_q  <= io_en_n;
      io_out_q <= io_out_n;
      rdata_q  <= rdata_n;
    end
  end

  // Next state: rising ticks sample, falling ticks advance the beat.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    beat_n    = beat_q;
    rx_n      = rx_q;
    sr_n      = sr_q;
    sck_n     = sck_q;
    ce_n      = ce_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    io_en_n   = io_en_q;
    io_out_n  = io_out_q;
    rdata_n   = rdata_q;
    update_io = 1'b0;
    drive     = 1'b0;
    ln        = lanes_f(mode_q, state_q);
    ln_n      = 4'd1;
    beats     = (state_q == WAIT) ? wait_q : beats_f(ln, state_q);

    if (state_q == IDLE) begin
      cnt_n = 8'd0;
      if (accept) begin
        state_n  = CMD;
        beat_n   = 8'd0;
        rx_n     = 8'd0;
        sr_n     = {cmd_i, {(SR_W-8){1'b0}}};
        ce_n     = 1'b0;
        sck_n    = 1'b0;
        busy_n   = 1'b1;
        io_en_n  = en_f(lanes_f(mode_i, CMD));
        io_out_n = drive_f(lanes_f(mode_i, CMD), {cmd_i, {(SR_W-8){1'b0}}});
      end
    end else if (!en_i) begin
      state_n  = IDLE;
      cnt_n    = 8'd0;
      beat_n   = 8'd0;
      ce_n     = 1'b1;
      sck_n    = 1'b0;
      busy_n   = 1'b0;
      io_en_n  = 8'h00;
      io_out_n = 8'h00;
    end else begin
      cnt_n = tick ? 8'd0 : 8'(cnt_q + 8'd1);
      if (tick) begin
        if (state_q == STOP) begin
          state_n = IDLE;
          ce_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          rdata_n = wr_q ? rdata_q : rx_q;
        end else if (!sck_q) begin
          sck_n = 1'b1;
          if (state_q == DATA && !wr_q) rx_n = sample_f(ln, rx_q, psram_io_in_i);
        end else begin
          sck_n     = 1'b0;
          update_io = 1'b1;
          if (beat_q != 8'(beats - 8'd1)) begin
            beat_n = 8'(beat_q + 8'd1);
            if (state_q != WAIT) sr_n = shift_f(ln, sr_q);
          end else begin
            beat_n = 8'd0;
            case (state_q)
              CMD: begin
                state_n = ADDR;
                sr_n    = addr_q;
              end
              ADDR: begin
                state_n = (wait_q != 8'd0) ? WAIT : DATA;
                sr_n    = {wdata_q, {(SR_W-8){1'b0}}};
              end
              WAIT:    state_n = DATA;
              DATA:    state_n = STOP;
              default: state_n = IDLE;
            endcase
          end
        end
      end
    end

    // Pads follow the phase that the next SCK low period belongs to.
    if (update_io) begin
      ln_n     = lanes_f(mode_q, state_n);
      drive    = (state_n == CMD) || (state_n == ADDR) || (state_n == DATA && wr_q);
      io_en_n  = drive ? en_f(ln_n) : 8'h00;
      io_out_n = drive ? drive_f(ln_n, sr_n) : 8'h00;
    end
  end

  assign rdata_o        = rdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign psram_sck_o    = sck_q;
  assign psram_ce_o     = ce_q;
  assign psram_io_en_o  = io_en_q;
  assign psram_io_out_o = io_out_q;

endmodule

// File: doc/psram_xfer.md
PSRAM_XFER -- requirements
Module: psram_xfer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, PSRAM byte address width; fixed at 24 for this revision.
REQ-002 SHALL have ports clk_i in 1, system clock; rst_n_i in 1, asynchronous active-low reset; one clock domain only.
REQ-003 SHALL have ports en_i in 1 (CTRL.EN); mode_i in 2 (CTRL.SWM: 00 SPI, 01 QSPI, 10 QPI, 11 OPI); pscr_i in 8 (SCK prescaler).
REQ-004 SHALL have ports start_i in 1, one-cycle transfer request; wr_i in 1 (1 write, 0 read); cmd_i in 8, opcode (WRC or RDC); wait_i in 8, dummy SCK cycles (WRW or RDW).
REQ-005 SHALL have ports addr_i in ADDR_WIDTH; wdata_i in 8; rdata_o out 8; busy_o out 1; done_o out 1, one-cycle completion pulse (STAT.DONE source).
REQ-006 SHALL have ports psram_sck_o out 1; psram_ce_o out 1 (active low); psram_io_en_o out 8 (1 = pad drives); psram_io_out_o out 8; psram_io_in_i in 8.

Function
REQ-007 SHALL sample cmd_i, addr_i, wdata_i, wr_i, mode_i, wait_i and pscr_i on the accepted start and ignore later changes until return to IDLE.
REQ-008 SHALL accept start_i only when en_i=1 and state IDLE; start_i otherwise ignored, no flags change.
REQ-009 SHALL use FSM IDLE -> CMD -> ADDR -> WAIT -> DATA -> STOP -> IDLE; WAIT skipped when captured wait=0.
REQ-010 SHALL produce an SCK tick every P clk cycles, P = max(captured pscr, 2); each tick toggles SCK; one SCK period = 2P clk.
REQ-011 SHALL keep SCK low when idle (mode 0); drive new output data after each falling edge (first bit with CE falling), sample input on each rising edge.
REQ-012 SHALL drop psram_ce_o one tick before the first SCK rising edge and raise it one tick after the last SCK falling edge.
REQ-013 SHALL use lanes per phase (cmd/addr/data): SPI 1/1/1, QSPI 1/4/4, QPI 4/4/4, OPI 8/8/8; MSB first; beats per phase = bits/lanes.
REQ-014 SHALL drive 1-lane output on io[0] (io_en 8'h01), 4-lane on io[3:0] (8'h0F), 8-lane on io[7:0] (8'hFF).
REQ-015 SHALL set io_en=8'h00 during WAIT, read DATA, STOP and IDLE; io_out=8'h00 whenever io_en=0.
REQ-016 SHALL sample read data from io[1] in SPI, io[3:0] in QSPI/QPI, io[7:0] in OPI, shifting MSB first.
REQ-017 SHALL update rdata_o only at read completion, holding it until next read completion; writes leave rdata_o unchanged.
REQ-018 SHALL count WAIT in full SCK cycles, exactly captured wait value, 1..255.
REQ-019 SHALL assert busy_o from the cycle after accepted start through the STOP state; done_o pulses for one clk in the cycle busy_o falls.
REQ-020 SHALL abort on en_i=0 mid-transfer: next cycle CE=1, SCK=0, io_en=0, busy=0, IDLE, no done_o pulse, rdata_o unchanged.
REQ-021 SHALL allow back-to-back transfers: start_i in the cycle after done_o is accepted.

Reset
REQ-022 SHALL on rst_n_i low, asynchronously: psram_ce_o=1, psram_sck_o=0, psram_io_en_o=0, psram_io_out_o=0, rdata_o=0, busy_o=0, done_o=0, FSM IDLE, counters 0.
REQ-023 SHALL, after reset release, need no start-up cycles; first start_i is accepted in the first clk with en_i=1.

Verification
REQ-024 SPI write: pscr=2, cmd=0x02, addr=0x000100, wdata=0xA5, wait=0 -> exactly 40 SCK rising edges while CE low; io[0] bitstream 0x02,0x000100,0xA5 MSB first; io_en=8'h01 throughout; single done_o pulse.
REQ-025 QPI read: pscr=3, cmd=0xEB, addr=0x123456, wait=6, model returns 0x3C -> 2+6+6+2=16 rising edges, SCK period 6 clk, io_en=0 in WAIT/DATA, rdata_o=0x3C after done_o.
REQ-026 Prescaler clamp: pscr=0 and pscr=1 -> SCK period 4 clk, identical to pscr=2.
REQ-027 Abort: en_i dropped in ADDR of SPI read -> next clk CE=1, SCK=0, busy=0, no done_o, rdata_o keeps prior value; new start then completes normally.
REQ-028 Ignored start: start_i pulsed while busy and with en_i=0 -> no extra CE low period, no extra done_o.
REQ-029 Reset mid-DATA of QSPI write -> all outputs at REQ-022 values asynchronously, before next clk edge.
